// File: rtl/acp_burst_writer.sv
// Moves a block from the stream BRAM into HPS memory through the f2h AXI3 slave using ACP-coherent writes.
// Transfers are split into INCR bursts of at most 16 beats. No burst crosses a 4 KB page.
module acp_burst_writer #(
    parameter int         BRAM_AW   = 10,
    parameter int         RD_LAT    = 1,
    parameter logic [7:0] AXI_ID    = 8'h00,
    parameter logic [3:0] ACP_CACHE = 4'b1111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        cfg_addr,
    input  logic [31:0]        cfg_len,
    input  logic               cfg_start,
    output logic               sts_busy,
    output logic               sts_done,
    output logic               sts_err,
    output logic               bram_rd_en,
    output logic [BRAM_AW-1:0] bram_rd_addr,
    input  logic [127:0]       bram_rd_data,
    output logic [31:0]        awaddr,
    output logic [3:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    output logic [1:0]         awlock,
    output logic [2:0]         awprot,
    output logic [3:0]         awcache,
    output logic [4:0]         awuser,
    output logic [7:0]         awid,
    output logic               awvalid,
    input  logic               awready,
    output logic [127:0]       wdata,
    output logic [15:0]        wstrb,
    output logic [7:0]         wid,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    input  logic [7:0]         bid,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);

    localparam int          BW      = BRAM_AW + 1;
    localparam logic [32:0] MAX_LEN = 33'(1) << (BRAM_AW + 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_AW,
        S_W,
        S_B,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic               start_prev_q;
    logic               start_edge;
    logic [31:0]        addr_q;
    logic [31:0]        len_q;
    logic [BW-1:0]      beats_left_q;
    logic [4:0]         burst_beats_q;
    logic [3:0]         awlen_q;
    logic [4:0]         reads_q;
    logic [4:0]         sent_q;
    logic [BRAM_AW-1:0] rd_addr_q;
    logic [RD_LAT-1:0]  pipe_q;
    logic [127:0]       fifo_mem [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         fifo_cnt_q;
    logic [2:0]         inflight;
    logic [2:0]         pending;
    logic               push;
    logic               pop;
    logic               cfg_zero;
    logic               cfg_bad;
    logic [4:0]         next_beats;
    logic               unused_bid;

    // Burst size limit: 16 beats, the remaining beats, or the beats left before the next 4 KB page.
    function automatic logic [4:0] burst_calc(input logic [11:0] page_off, input logic [BW-1:0] left);
        logic [12:0] room_bytes;
        logic [8:0]  room;
        logic [4:0]  n;
        room_bytes = 13'h1000 - {1'b0, page_off};
        room       = room_bytes[12:4];
        n          = 5'd16;
        if (left < BW'(16))
            n = 5'(left);
        if (room < 9'(n))
            n = 5'(room);
        return n;
    endfunction

    assign start_edge = cfg_start & ~start_prev_q;
    assign cfg_zero   = (len_q == 32'd0);
    assign cfg_bad    = (addr_q[3:0] != 4'd0) || (len_q[3:0] != 4'd0) || ({1'b0, len_q} > MAX_LEN);
    assign next_beats = burst_calc(addr_q[11:0], beats_left_q);

    assign push    = pipe_q[RD_LAT-1];
    assign wvalid  = (fifo_cnt_q != 2'd0);
    assign pop     = wvalid & wready;
    assign wlast   = wvalid && (sent_q == burst_beats_q - 5'd1);
    assign wdata   = fifo_mem[rd_ptr_q];
    assign wstrb   = 16'hFFFF;
    assign wid     = AXI_ID;

    assign awaddr  = addr_q;
    assign awlen   = awlen_q;
    assign awsize  = 3'b100;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awprot  = 3'b000;
    assign awcache = ACP_CACHE;
    assign awuser  = 5'b00001;
    assign awid    = AXI_ID;
    assign awvalid = (state_q == S_AW);
    assign bready  = (state_q == S_B);

    assign bram_rd_addr = rd_addr_q;
    assign unused_bid   = ^bid;

    // Reads are issued only while FIFO entries plus reads in flight stay within the two FIFO slots.
    // A pop in the same cycle frees one slot, which keeps W beats at full rate.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++)
            inflight = inflight + 3'(pipe_q[i]);
        pending    = {1'b0, fifo_cnt_q} + inflight;
        bram_rd_en = (state_q == S_W) && (reads_q < burst_beats_q) &&
                     ((pending < 3'd2) || ((pending == 3'd2) && pop));
    end

    // NOTE: every combinational output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_edge) state_d = S_CHECK;
            S_CHECK: state_d = (cfg_zero || cfg_bad) ? S_FIN : S_AW;
            S_AW:    if (awready) state_d = S_W;
            S_W:     if (pop && wlast) state_d = S_B;
            S_B: begin
                if (bvalid)
                    state_d = ((bresp != 2'b00) || (beats_left_q == '0)) ? S_FIN : S_AW;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            // A level that is already high when reset releases does not start a transfer.
            start_prev_q  <= 1'b1;
            addr_q        <= '0;
            len_q         <= '0;
            beats_left_q  <= '0;
            burst_beats_q <= '0;
            awlen_q       <= '0;
            reads_q       <= '0;
            sent_q        <= '0;
            rd_addr_q     <= '0;
            pipe_q        <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= '0;
            sts_busy      <= 1'b0;
            sts_done      <= 1'b0;
            sts_err       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= cfg_start;

            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        addr_q       <= cfg_addr;
                        len_q        <= cfg_len;
                        beats_left_q <= cfg_len[BRAM_AW+4:4];
                        rd_addr_q    <= '0;
                        sts_busy     <= 1'b1;
                        sts_done     <= 1'b0;
                        sts_err      <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (!cfg_zero && cfg_bad) begin
                        sts_err <= 1'b1;
                    end else if (!cfg_zero) begin
                        burst_beats_q <= next_beats;
                        awlen_q       <= 4'(next_beats - 5'd1);
                    end
                end
                S_AW: begin
                    if (awready) begin
                        addr_q       <= addr_q + (32'(burst_beats_q) << 4);
                        beats_left_q <= beats_left_q - BW'(burst_beats_q);
                        reads_q      <= '0;
                        sent_q       <= '0;
                    end
                end
                S_B: begin
                    if (bvalid && (bresp != 2'b00)) begin
                        sts_err <= 1'b1;
                    end else if (bvalid && (beats_left_q != '0)) begin
                        burst_beats_q <= next_beats;
                        awlen_q       <= 4'(next_beats - 5'd1);
                    end
                end
                S_FIN: begin
                    sts_busy <= 1'b0;
                    sts_done <= 1'b1;
                end
                default: ;
            endcase

            if (bram_rd_en) begin
                rd_addr_q <= rd_addr_q + 1'b1;
                reads_q   <= reads_q + 5'd1;
            end
            if (pop)
                sent_q <= sent_q + 5'd1;

            pipe_q[0] <= bram_rd_en;
            for (int i = 1; i < RD_LAT; i++)
                pipe_q[i] <= pipe_q[i-1];

            if (push)
                wr_ptr_q <= ~wr_ptr_q;
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // NOTE: the data slots are not reset; the occupancy count alone decides whether an entry is valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= bram_rd_data;
    end

endmodule

// File: tb/tb_acp_burst_writer.sv
// Directed bench for acp_burst_writer: a table of transfers run against an AXI slave and BRAM model,
// followed by hand-written sequences for the len-0 timing, held start, and mid-transfer reset cases.
module tb_acp_burst_writer;

    localparam int BRAM_AW = 10;
    localparam int BUDGET  = 5000;

    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        cfg_addr, cfg_len;
    logic               cfg_start;
    logic               sts_busy, sts_done, sts_err;
    logic               bram_rd_en;
    logic [BRAM_AW-1:0] bram_rd_addr;
    logic [127:0]       bram_rd_data;
    logic [31:0]        awaddr;
    logic [3:0]         awlen;
    logic [2:0]         awsize;
    logic [1:0]         awburst, awlock;
    logic [2:0]         awprot;
    logic [3:0]         awcache;
    logic [4:0]         awuser;
    logic [7:0]         awid;
    logic               awvalid, awready;
    logic [127:0]       wdata;
    logic [15:0]        wstrb;
    logic [7:0]         wid;
    logic               wlast, wvalid, wready;
    logic [7:0]         bid;
    logic [1:0]         bresp;
    logic               bvalid, bready;

    acp_burst_writer #(
        .BRAM_AW(BRAM_AW), .RD_LAT(1), .AXI_ID(8'h00), .ACP_CACHE(4'b1111)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_start(cfg_start),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err),
        .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awprot(awprot), .awcache(awcache), .awuser(awuser), .awid(awid),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wid(wid), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] word(input int i);
        return {32'hC0DE_0000 + 32'(i), ~32'(i), 32'h1234_5678 ^ 32'(i), 32'(i) * 32'd3};
    endfunction

    // BRAM model with one cycle of read latency.
    always @(posedge clk)
        if (bram_rd_en)
            bram_rd_data <= word(int'(bram_rd_addr));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        bit          stall;
        int          err_burst;
        bit          poke;
        int          exp_bursts;
        logic [31:0] exp_aw0;
        logic [3:0]  exp_len0;
        logic [31:0] exp_aw1;
        logic [3:0]  exp_len1;
        int          exp_beats;
        bit          exp_err;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_errors = 0;

    // Slave model and monitor state.
    bit          stall_mode = 1'b0;
    int          err_burst  = -1;
    logic [31:0] aw_addr_h [$];
    logic [3:0]  aw_len_h [$];
    int          beat_idx, beat_in_burst, w_burst, b_idx, pending_b;
    int          data_err, proto_err;
    bit          b_hs, aw_pend, w_pend, w_last_exp;
    logic [31:0] aw_pend_addr;
    logic [3:0]  aw_pend_len;
    logic [127:0] w_pend_data;
    logic        w_pend_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_tracking();
        aw_addr_h.delete();
        aw_len_h.delete();
        beat_idx      = 0;
        beat_in_burst = 0;
        w_burst       = 0;
        b_idx         = 0;
        pending_b     = 0;
        data_err      = 0;
        proto_err     = 0;
    endtask

    // AXI slave: decides ready/valid on the falling edge and records the handshakes for the next rising edge.
    initial begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        bid     = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                bvalid    = 1'b0;
                b_hs      = 1'b0;
                aw_pend   = 1'b0;
                w_pend    = 1'b0;
                pending_b = 0;
            end else begin
                if (b_hs) begin
                    bvalid    = 1'b0;
                    b_idx++;
                    pending_b--;
                    b_hs = 1'b0;
                end
                if (aw_pend && (!awvalid || awaddr !== aw_pend_addr || awlen !== aw_pend_len))
                    proto_err++;
                if (w_pend && (!wvalid || wdata !== w_pend_data || wlast !== w_pend_last))
                    proto_err++;
                awready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
                wready  = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (!bvalid && pending_b > 0 && (!stall_mode || $urandom_range(0, 2) == 0)) begin
                    bvalid = 1'b1;
                    bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
                end
                if (awvalid && awready) begin
                    aw_addr_h.push_back(awaddr);
                    aw_len_h.push_back(awlen);
                    if (awsize !== 3'b100 || awburst !== 2'b01 || awlock !== 2'b00 || awprot !== 3'b000 ||
                        awcache !== 4'b1111 || awuser !== 5'b00001 || awid !== 8'h00)
                        proto_err++;
                end
                if (wvalid && wready) begin
                    if (w_burst >= aw_len_h.size()) begin
                        proto_err++;
                        w_last_exp = 1'b0;
                    end else begin
                        w_last_exp = (beat_in_burst == int'(aw_len_h[w_burst]));
                    end
                    if (wdata !== word(beat_idx) || wlast !== w_last_exp || wstrb !== 16'hFFFF || wid !== 8'h00)
                        data_err++;
                    beat_idx++;
                    beat_in_burst++;
                    if (wlast) begin
                        w_burst++;
                        beat_in_burst = 0;
                        pending_b++;
                    end
                end
                aw_pend      = awvalid && !awready;
                aw_pend_addr = awaddr;
                aw_pend_len  = awlen;
                w_pend       = wvalid && !wready;
                w_pend_data  = wdata;
                w_pend_last  = wlast;
                b_hs         = bvalid && bready;
            end
        end
    end

    task automatic run_vector(input vec_t v, input int idx);
        int cyc;
        clear_tracking();
        stall_mode = v.stall;
        err_burst  = v.err_burst;
        @(negedge clk);
        cfg_addr  = v.addr;
        cfg_len   = v.len;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        if (v.poke) begin
            repeat (10) @(negedge clk);
            check($sformatf("v%0d_busy_at_poke", idx), sts_busy, 1);
            cfg_addr  = 32'h4000_0000;
            cfg_len   = 32'd16;
            cfg_start = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
        end
        cyc = 0;
        while (!sts_done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d_done_within_budget", idx), (cyc < BUDGET), 1);
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_bursts", idx), aw_addr_h.size(), v.exp_bursts);
        if (v.exp_bursts >= 1 && aw_addr_h.size() >= 1) begin
            check($sformatf("v%0d_awaddr0", idx), aw_addr_h[0], v.exp_aw0);
            check($sformatf("v%0d_awlen0", idx), aw_len_h[0], v.exp_len0);
        end
        if (v.exp_bursts >= 2 && aw_addr_h.size() >= 2) begin
            check($sformatf("v%0d_awaddr1", idx), aw_addr_h[1], v.exp_aw1);
            check($sformatf("v%0d_awlen1", idx), aw_len_h[1], v.exp_len1);
        end
        check($sformatf("v%0d_beats", idx), beat_idx, v.exp_beats);
        check($sformatf("v%0d_bresps", idx), b_idx, v.exp_bursts);
        check($sformatf("v%0d_data_errs", idx), data_err, 0);
        check($sformatf("v%0d_protocol_errs", idx), proto_err, 0);
        check($sformatf("v%0d_err", idx), sts_err, v.exp_err);
        check($sformatf("v%0d_done", idx), sts_done, 1);
        check($sformatf("v%0d_busy", idx), sts_busy, 0);
    endtask

    initial begin
        int cyc;
        int busy_cnt;

        //               addr          len     stall err_b poke bursts aw0           l0     aw1           l1     beats err
        vecs[0] = '{32'h3000_0000, 32'd256,   1'b0, -1, 1'b0, 1,  32'h3000_0000, 4'd15, 32'h0,         4'd0,  16,   1'b0};
        vecs[1] = '{32'h3000_0FC0, 32'd128,   1'b0, -1, 1'b0, 2,  32'h3000_0FC0, 4'd3,  32'h3000_1000, 4'd3,  8,    1'b0};
        vecs[2] = '{32'h3000_0000, 32'd400,   1'b1, -1, 1'b1, 2,  32'h3000_0000, 4'd15, 32'h3000_0100, 4'd8,  25,   1'b0};
        vecs[3] = '{32'h3000_0000, 32'd0,     1'b0, -1, 1'b0, 0,  32'h0,         4'd0,  32'h0,         4'd0,  0,    1'b0};
        vecs[4] = '{32'h3000_0008, 32'd32,    1'b0, -1, 1'b0, 0,  32'h0,         4'd0,  32'h0,         4'd0,  0,    1'b1};
        vecs[5] = '{32'h3000_0000, 32'd20,    1'b0, -1, 1'b0, 0,  32'h0,         4'd0,  32'h0,         4'd0,  0,    1'b1};
        vecs[6] = '{32'h3000_0000, 32'd16400, 1'b0, -1, 1'b0, 0,  32'h0,         4'd0,  32'h0,         4'd0,  0,    1'b1};
        vecs[7] = '{32'h3000_0000, 32'd512,   1'b0, 0,  1'b0, 1,  32'h3000_0000, 4'd15, 32'h0,         4'd0,  16,   1'b1};
        vecs[8] = '{32'h3000_0FF0, 32'd48,    1'b1, -1, 1'b0, 2,  32'h3000_0FF0, 4'd0,  32'h3000_1000, 4'd1,  3,    1'b0};
        vecs[9] = '{32'h3000_0000, 32'd16384, 1'b0, -1, 1'b0, 64, 32'h3000_0000, 4'd15, 32'h3000_0100, 4'd15, 1024, 1'b0};

        reset     = 1'b1;
        cfg_addr  = '0;
        cfg_len   = '0;
        cfg_start = 1'b0;
        clear_tracking();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {awvalid, wvalid, bready, bram_rd_en, sts_busy, sts_done, sts_err}, 0);
        check("reset_awlen", awlen, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++)
            run_vector(vecs[i], i);

        // Zero length finishes three cycles after the start edge; holding start high must not retrigger.
        clear_tracking();
        stall_mode = 1'b0;
        err_burst  = -1;
        @(negedge clk);
        cfg_addr  = 32'h3000_0000;
        cfg_len   = 32'd0;
        cfg_start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("len0_busy_cycle2", sts_busy, 1);
        check("len0_done_cycle2", sts_done, 0);
        @(posedge clk);
        #1;
        check("len0_done_cycle3", sts_done, 1);
        check("len0_busy_cycle3", sts_busy, 0);
        busy_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (sts_busy)
                busy_cnt++;
        end
        check("held_start_no_retrigger", busy_cnt, 0);
        check("len0_no_aw", aw_addr_h.size(), 0);
        @(negedge clk);
        cfg_start = 1'b0;

        // Reset while W beats are flowing.
        clear_tracking();
        @(negedge clk);
        cfg_addr  = 32'h3000_0000;
        cfg_len   = 32'd256;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cyc = 0;
        while (!wvalid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_w", (cyc < 100), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_w_outputs", {awvalid, wvalid, bready, bram_rd_en, sts_busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_vector(vecs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
